// File: rtl/mux_arb_reg.sv
// mux_arb_reg
// Registered NCH-channel, WIDTH-bit selector with a valid/ready handshake on
// every input channel and on the single output.
//
// Two selection modes:
//   mode = 0  manual     : the channel named by `control` is granted if it is
//                          valid. An out-of-range `control` grants nothing.
//   mode = 1  arbitrate  : the first valid channel is granted. The search is
//                          fixed priority (lowest index wins) by default, or
//                          round-robin when MUX_ARB_RR_EN is defined.
//
// Build option:
//   MUX_ARB_RR_EN  defined   -> round-robin arbitration with pointer rr_ptr
//                  undefined -> fixed-priority arbitration, no rr_ptr
//
// Ports:
//   clock      in   1          rising-edge clock
//   reset_n    in   1          asynchronous active-low reset
//   in_data    in   NCH*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   in_valid   in   NCH        per-channel valid
//   in_ready   out  NCH        per-channel ready (one-hot or zero)
//   mode       in   1          0 = manual, 1 = arbitrate
//   control    in   SELW       manual channel select
//   out_data   out  WIDTH      registered data
//   out_chan   out  SELW       source channel of out_data
//   out_valid  out  1          output register holds a word
//   out_ready  in   1          consumer accepts the held word
module mux_arb_reg #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      control,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             slot_free;
    logic             load;
    logic             grant_valid;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;

    logic             man_valid;
    logic             arb_valid;
    logic [SELW-1:0]  arb_sel;

    // The output register can take a new word when it is empty or when the
    // word it holds leaves on this same edge.
    assign slot_free = !out_valid || out_ready;

    // Manual select. Matching against every legal index (instead of indexing
    // in_valid with control directly) makes control >= NCH grant nothing.
    always_comb begin
        man_valid = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (control == SELW'(k) && in_valid[k]) begin
                man_valid = 1'b1;
            end
        end
    end

`ifdef MUX_ARB_RR_EN
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] cand;

    // Round-robin search starting one past the last arbitrated grant.
    always_comb begin
        arb_valid = 1'b0;
        arb_sel   = '0;
        cand      = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = SELW'((int'(rr_ptr) + i) % NCH);
            if (!arb_valid && in_valid[cand]) begin
                arb_valid = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    // Reset value NCH-1 makes the first search after reset begin at channel 0.
    // Manual-mode transfers leave the pointer alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= SELW'(NCH - 1);
        end else if (load && mode) begin
            rr_ptr <= grant;
        end
    end
`else
    // Fixed priority: scanning downwards leaves the lowest valid index.
    always_comb begin
        arb_valid = 1'b0;
        arb_sel   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                arb_valid = 1'b1;
                arb_sel   = SELW'(k);
            end
        end
    end
`endif

    assign grant       = mode ? arb_sel   : control;
    assign grant_valid = mode ? arb_valid : man_valid;
    assign load        = slot_free && grant_valid;

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant == SELW'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // reset_n gates in_ready so no producer sees a handshake while the
    // output register is being held in reset.
    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            in_ready[k] = reset_n && load && (grant == SELW'(k));
        end
    end

    // Load has precedence over drain, so a word leaving and a word arriving
    // on the same edge produce no bubble. Data and channel hold on drain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= grant_data;
            out_chan  <= grant;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
